// File: rtl/lstm_pkg.sv
// Shared definitions for the LSTM command dispatcher.
//   DATA_W           width of one job payload and of one Ct or Ht vector
//   CTX_W            width of one stored branch context {Ct, Ht}
//   SYS_type/BR_type job type encodings on iReq_type / oType / oResp_type
//   dispatch_state_e dispatcher FSM states
package lstm_pkg;

  localparam int DATA_W = 512;
  localparam int CTX_W  = 2 * DATA_W;

  localparam logic SYS_type = 1'b0;
  localparam logic BR_type  = 1'b1;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_LOAD,
    ST_ISSUE,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_WRITEBACK,
    ST_ERROR
  } dispatch_state_e;

endpackage

// File: rtl/lstm_ctx_ram.sv
// Branch context store: DEPTH entries of WIDTH bits, one write port and one
// read port with a registered output.
//   clk      clock, rising edge
//   reset    synchronous active-high; clears the read register only
//   wr_en    write enable
//   wr_addr  write address
//   wr_data  write data
//   rd_en    read enable; rd_data updates on the following cycle
//   rd_addr  read address
//   rd_data  registered read data
module lstm_ctx_ram
  import lstm_pkg::*;
#(
  parameter int  DEPTH = 16,
  parameter int  WIDTH = CTX_W,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // Storage array carries no reset; the dispatcher zeroes it through the
  // write port after every reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Output register with synchronous reset so the context outputs read zero
  // straight after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q <= '0;
    end else if (rd_en) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/lstm_dispatch.sv
// Initiator side of the LSTM core command interface. Accepts {type, branch
// id, data} jobs, loads the branch context into the core for BR jobs, issues
// the job, waits for the core's done handshake, writes the new context back
// and returns a response.
//   clk, reset                  clock and synchronous active-high reset
//   iReq_*/oReq_ready           job request stream (valid/ready)
//   iCtx_clear                  pulse: zero all branch contexts
//   oLoad_valid, oBr_*_load     context load towards the core
//   oNext_valid, oType, oData   job start towards the core
//   iLstm_done, iBr_Ct, iBr_Ht  core status and results
//   oResp_*                     completion pulse with id, type and latency
//   oError                      sticky timeout flag
module lstm_dispatch
  import lstm_pkg::*;
#(
  parameter int  NUM_BR  = 16,
  parameter int  TIMEOUT = 2047,
  parameter int  LAT_W   = 12,
  localparam int BR_W    = $clog2(NUM_BR)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iReq_valid,
  output logic              oReq_ready,
  input  logic              iReq_type,
  input  logic [BR_W-1:0]   iReq_br_id,
  input  logic [DATA_W-1:0] iReq_data,
  input  logic              iCtx_clear,
  output logic              oLoad_valid,
  output logic [DATA_W-1:0] oBr_Ct_load,
  output logic [DATA_W-1:0] oBr_Ht_load,
  output logic              oNext_valid,
  output logic              oType,
  output logic [DATA_W-1:0] oData,
  input  logic              iLstm_done,
  input  logic [DATA_W-1:0] iBr_Ct,
  input  logic [DATA_W-1:0] iBr_Ht,
  output logic              oResp_valid,
  output logic [BR_W-1:0]   oResp_br_id,
  output logic              oResp_type,
  output logic [LAT_W-1:0]  oResp_lat,
  output logic              oError
);

  localparam int               TMR_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [BR_W-1:0]  CLR_LAST = BR_W'(NUM_BR - 1);

  dispatch_state_e   state_q, state_d;
  logic [BR_W-1:0]   clr_idx_q, clr_idx_d;
  logic              job_type_q, job_type_d;
  logic [BR_W-1:0]   job_id_q, job_id_d;
  logic [DATA_W-1:0] job_data_q, job_data_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic              load_valid_q, load_valid_d;
  logic              next_valid_q, next_valid_d;
  logic              resp_valid_q, resp_valid_d;
  logic [BR_W-1:0]   resp_id_q, resp_id_d;
  logic              resp_type_q, resp_type_d;
  logic [LAT_W-1:0]  resp_lat_q, resp_lat_d;
  logic              error_q, error_d;

  logic              req_ready;
  logic              req_accept;
  logic [LAT_W-1:0]  lat_inc;

  logic              ram_wr_en;
  logic [BR_W-1:0]   ram_wr_addr;
  logic [CTX_W-1:0]  ram_wr_data;
  logic [CTX_W-1:0]  ram_rd_data;

  // The core can only take a new job while it reports idle, and a clear
  // request in the same cycle takes priority over the job.
  assign req_ready  = ~reset & (state_q == ST_IDLE) & iLstm_done & ~iCtx_clear;
  assign req_accept = iReq_valid & req_ready;

  assign lat_inc = (&lat_q) ? lat_q : lat_q + LAT_W'(1);

  always_comb begin
    state_d     = state_q;
    clr_idx_d   = clr_idx_q;
    job_type_d  = job_type_q;
    job_id_d    = job_id_q;
    job_data_d  = job_data_q;
    lat_d       = lat_q;
    resp_valid_d = 1'b0;
    resp_id_d   = resp_id_q;
    resp_type_d = resp_type_q;
    resp_lat_d  = resp_lat_q;

    unique case (state_q)
      ST_CLEAR: begin
        clr_idx_d = clr_idx_q + BR_W'(1);
        if (clr_idx_q == CLR_LAST) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        clr_idx_d = '0;
        if (iCtx_clear) begin
          state_d = ST_CLEAR;
        end else if (req_accept) begin
          job_type_d = iReq_type;
          job_id_d   = iReq_br_id;
          job_data_d = iReq_data;
          state_d    = (iReq_type == BR_type) ? ST_LOAD : ST_ISSUE;
        end
      end
      ST_LOAD: begin
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        lat_d   = '0;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (!iLstm_done) begin
          state_d = ST_WAIT_DONE;
        end else if (tmr_q == TMR_LAST) begin
          state_d = ST_ERROR;
        end
      end
      ST_WAIT_DONE: begin
        lat_d = lat_inc;
        // A done seen on the final timeout cycle still completes the job.
        if (iLstm_done) begin
          resp_valid_d = 1'b1;
          resp_id_d    = job_id_q;
          resp_type_d  = job_type_q;
          resp_lat_d   = lat_inc;
          state_d      = (job_type_q == BR_type) ? ST_WRITEBACK : ST_IDLE;
        end else if (tmr_q == TMR_LAST) begin
          state_d = ST_ERROR;
        end
      end
      ST_WRITEBACK: begin
        state_d = ST_IDLE;
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        state_d = ST_ERROR;
      end
    endcase

    // Timeout counter restarts on every state change and only runs in the
    // two wait states, so each wait gets its own TIMEOUT budget.
    if ((state_d == state_q) &&
        ((state_q == ST_WAIT_BUSY) || (state_q == ST_WAIT_DONE))) begin
      tmr_d = tmr_q + TMR_W'(1);
    end else begin
      tmr_d = '0;
    end

    // Strobes are registered so they line up with the state they belong to.
    load_valid_d = (state_d == ST_LOAD);
    next_valid_d = (state_d == ST_ISSUE);
    error_d      = error_q | (state_d == ST_ERROR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_CLEAR;
      clr_idx_q    <= '0;
      job_type_q   <= 1'b0;
      job_id_q     <= '0;
      job_data_q   <= '0;
      tmr_q        <= '0;
      lat_q        <= '0;
      load_valid_q <= 1'b0;
      next_valid_q <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_type_q  <= 1'b0;
      resp_lat_q   <= '0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_idx_q    <= clr_idx_d;
      job_type_q   <= job_type_d;
      job_id_q     <= job_id_d;
      job_data_q   <= job_data_d;
      tmr_q        <= tmr_d;
      lat_q        <= lat_d;
      load_valid_q <= load_valid_d;
      next_valid_q <= next_valid_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_type_q  <= resp_type_d;
      resp_lat_q   <= resp_lat_d;
      error_q      <= error_d;
    end
  end

  // Context RAM: CLEAR and WRITEBACK share the write port (never active
  // together). The read is launched on the accept edge so the registered
  // context is presented during LOAD.
  assign ram_wr_en   = ~reset & ((state_q == ST_CLEAR) | (state_q == ST_WRITEBACK));
  assign ram_wr_addr = (state_q == ST_CLEAR) ? clr_idx_q : job_id_q;
  assign ram_wr_data = (state_q == ST_CLEAR) ? '0 : {iBr_Ct, iBr_Ht};

  lstm_ctx_ram #(
    .DEPTH (NUM_BR),
    .WIDTH (CTX_W)
  ) u_ctx_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (ram_wr_en),
    .wr_addr (ram_wr_addr),
    .wr_data (ram_wr_data),
    .rd_en   (req_accept),
    .rd_addr (iReq_br_id),
    .rd_data (ram_rd_data)
  );

  assign oReq_ready  = req_ready;
  assign oLoad_valid = load_valid_q;
  assign oBr_Ct_load = ram_rd_data[CTX_W-1:DATA_W];
  assign oBr_Ht_load = ram_rd_data[DATA_W-1:0];
  assign oNext_valid = next_valid_q;
  assign oType       = job_type_q;
  assign oData       = job_data_q;
  assign oResp_valid = resp_valid_q;
  assign oResp_br_id = resp_id_q;
  assign oResp_type  = resp_type_q;
  assign oResp_lat   = resp_lat_q;
  assign oError      = error_q;

endmodule

// File: tb/tb_lstm_dispatch.sv
// Scoreboard bench for lstm_dispatch. The driver pushes the expected load,
// issue and response of every job into queues; a monitor pops and compares
// them whenever the DUT strobes oLoad_valid, oNext_valid or oResp_valid. A
// small core model drops done after each issue for a per-job busy time and
// returns Ct/Ht values derived from the job sequence number.
module tb_lstm_dispatch;
  import lstm_pkg::*;

  localparam int NUM_BR  = 16;
  localparam int BR_W    = 4;
  localparam int LAT_W   = 12;
  localparam int TIMEOUT = 2047;

  logic              clk = 1'b0;
  logic              reset;
  logic              iReq_valid;
  logic              oReq_ready;
  logic              iReq_type;
  logic [BR_W-1:0]   iReq_br_id;
  logic [DATA_W-1:0] iReq_data;
  logic              iCtx_clear;
  logic              oLoad_valid;
  logic [DATA_W-1:0] oBr_Ct_load;
  logic [DATA_W-1:0] oBr_Ht_load;
  logic              oNext_valid;
  logic              oType;
  logic [DATA_W-1:0] oData;
  logic              iLstm_done;
  logic [DATA_W-1:0] iBr_Ct;
  logic [DATA_W-1:0] iBr_Ht;
  logic              oResp_valid;
  logic [BR_W-1:0]   oResp_br_id;
  logic              oResp_type;
  logic [LAT_W-1:0]  oResp_lat;
  logic              oError;

  always #5 clk = ~clk;

  lstm_dispatch #(
    .NUM_BR  (NUM_BR),
    .TIMEOUT (TIMEOUT),
    .LAT_W   (LAT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .iReq_valid  (iReq_valid),
    .oReq_ready  (oReq_ready),
    .iReq_type   (iReq_type),
    .iReq_br_id  (iReq_br_id),
    .iReq_data   (iReq_data),
    .iCtx_clear  (iCtx_clear),
    .oLoad_valid (oLoad_valid),
    .oBr_Ct_load (oBr_Ct_load),
    .oBr_Ht_load (oBr_Ht_load),
    .oNext_valid (oNext_valid),
    .oType       (oType),
    .oData       (oData),
    .iLstm_done  (iLstm_done),
    .iBr_Ct      (iBr_Ct),
    .iBr_Ht      (iBr_Ht),
    .oResp_valid (oResp_valid),
    .oResp_br_id (oResp_br_id),
    .oResp_type  (oResp_type),
    .oResp_lat   (oResp_lat),
    .oError      (oError)
  );

  typedef struct packed {
    logic              typ;
    logic [DATA_W-1:0] data;
  } issue_t;

  typedef struct packed {
    logic [BR_W-1:0]  id;
    logic             typ;
    logic [LAT_W-1:0] lat;
  } resp_t;

  int checks = 0;
  int fails  = 0;

  logic [CTX_W-1:0] load_q[$];
  issue_t           issue_q[$];
  resp_t            resp_q[$];
  int               core_cfg_q[$];
  logic [CTX_W-1:0] ctx_model [NUM_BR];
  int               job_k = 0;
  int               waits;

  function automatic logic [DATA_W-1:0] mk_ct(input int k);
    return {16{32'hC7000000 + 32'(k)}};
  endfunction

  function automatic logic [DATA_W-1:0] mk_ht(input int k);
    return {16{32'h4E000000 + 32'(k)}};
  endfunction

  function automatic logic [DATA_W-1:0] mk_data(input int k);
    return {16{32'hDA7A0000 + 32'(k)}};
  endfunction

  task automatic chk(input string name, input logic [DATA_W-1:0] act,
                     input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic zero_model();
    for (int i = 0; i < NUM_BR; i++) ctx_model[i] = '0;
  endtask

  // Queue the expectations for one job, then hold the request until it is
  // accepted. Called at a falling edge; returns at the falling edge after
  // the accepting edge. waits = number of cycles ready was low.
  task automatic send_job(input logic typ, input logic [BR_W-1:0] id,
                          input int busy, output int n_wait);
    issue_t is;
    resp_t  rs;
    logic [DATA_W-1:0] d;
    d = mk_data(job_k);
    if (typ == BR_type) begin
      load_q.push_back(ctx_model[id]);
      if (busy >= 0) ctx_model[id] = {mk_ct(job_k), mk_ht(job_k)};
    end
    is.typ = typ;
    is.data = d;
    issue_q.push_back(is);
    if (busy >= 0) begin
      rs.id  = id;
      rs.typ = typ;
      rs.lat = LAT_W'(busy);
      resp_q.push_back(rs);
    end
    core_cfg_q.push_back(busy);
    job_k++;
    iReq_valid = 1'b1;
    iReq_type  = typ;
    iReq_br_id = id;
    iReq_data  = d;
    n_wait = 0;
    #1;
    while (!oReq_ready && n_wait < 200) begin
      @(negedge clk);
      #1;
      n_wait++;
    end
    checks++;
    if (oReq_ready !== 1'b1) begin
      fails++;
      $display("FAIL req_accept: ready still %b after %0d cycles", oReq_ready, n_wait);
    end
    @(negedge clk);
    iReq_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((resp_q.size() != 0 || issue_q.size() != 0 || load_q.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", DATA_W'(resp_q.size() + issue_q.size() + load_q.size()), '0);
    @(negedge clk);
  endtask

  // Core model: on each issue, drop done for the configured number of
  // cycles, then present the results and raise done. Negative = never busy.
  initial begin
    int busy;
    int kk;
    int core_n;
    core_n     = 0;
    iLstm_done = 1'b1;
    iBr_Ct     = '0;
    iBr_Ht     = '0;
    forever begin
      @(negedge clk);
      if (oNext_valid === 1'b1) begin
        busy = (core_cfg_q.size() != 0) ? core_cfg_q.pop_front() : -1;
        kk = core_n;
        core_n++;
        if (busy >= 0) begin
          iLstm_done = 1'b0;
          repeat (busy + 1) @(negedge clk);
          iBr_Ct = mk_ct(kk);
          iBr_Ht = mk_ht(kk);
          iLstm_done = 1'b1;
        end
      end
    end
  end

  // Monitor
  logic             load_prev = 1'b0;
  logic             next_prev = 1'b0;
  logic             resp_prev = 1'b0;
  logic [CTX_W-1:0] ml;
  issue_t           mi;
  resp_t            mr;

  always @(negedge clk) begin
    if (oLoad_valid === 1'b1) begin
      chk("load_pulse", DATA_W'(load_prev), '0);
      if (load_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL load_unexpected: oLoad_valid=1 with no load expected");
      end else begin
        ml = load_q.pop_front();
        chk("load_ct", oBr_Ct_load, ml[CTX_W-1:DATA_W]);
        chk("load_ht", oBr_Ht_load, ml[DATA_W-1:0]);
      end
    end
    if (oNext_valid === 1'b1) begin
      chk("issue_pulse", DATA_W'(next_prev), '0);
      if (issue_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL issue_unexpected: oNext_valid=1 with no issue expected");
      end else begin
        mi = issue_q.pop_front();
        chk("issue_type", DATA_W'(oType), DATA_W'(mi.typ));
        chk("issue_data", oData, mi.data);
      end
    end
    if (oResp_valid === 1'b1) begin
      chk("resp_pulse", DATA_W'(resp_prev), '0);
      if (resp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL resp_unexpected: oResp_valid=1 with no response expected");
      end else begin
        mr = resp_q.pop_front();
        $display("resp id=%0d type=%0d lat=%0d (expected id=%0d type=%0d lat=%0d)",
                 oResp_br_id, oResp_type, oResp_lat, mr.id, mr.typ, mr.lat);
        chk("resp_id", DATA_W'(oResp_br_id), DATA_W'(mr.id));
        chk("resp_type", DATA_W'(oResp_type), DATA_W'(mr.typ));
        chk("resp_lat", DATA_W'(oResp_lat), DATA_W'(mr.lat));
      end
    end
    load_prev <= oLoad_valid;
    next_prev <= oNext_valid;
    resp_prev <= oResp_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset      = 1'b1;
    iCtx_clear = 1'b0;
    zero_model();
    // Request already pending while reset is applied.
    iReq_valid = 1'b1;
    iReq_type  = BR_type;
    iReq_br_id = '0;
    iReq_data  = mk_data(0);
    repeat (3) @(negedge clk);

    chk("rst_ready", DATA_W'(oReq_ready), '0);
    chk("rst_load_valid", DATA_W'(oLoad_valid), '0);
    chk("rst_next_valid", DATA_W'(oNext_valid), '0);
    chk("rst_resp_valid", DATA_W'(oResp_valid), '0);
    chk("rst_error", DATA_W'(oError), '0);
    chk("rst_resp_lat", DATA_W'(oResp_lat), '0);
    chk("rst_ct_load", oBr_Ct_load, '0);
    chk("rst_data", oData, '0);

    // 1: CLEAR keeps ready low for 16 cycles; first BR job loads zeros.
    reset = 1'b0;
    send_job(BR_type, 4'd0, 10, waits);
    chk("clear_wait_cycles", DATA_W'(waits), DATA_W'(16));
    wait_idle();

    // 2: BR job on id 3, core busy for 10 cycles.
    send_job(BR_type, 4'd3, 10, waits);
    wait_idle();

    // 3: SYS job, no load and no context change.
    send_job(SYS_type, 4'd0, 7, waits);
    wait_idle();

    // ctx[3] must still hold the result of test 2.
    send_job(BR_type, 4'd3, 3, waits);
    wait_idle();

    // 4: back-to-back BR jobs on id 5; the second waits for the first to
    // finish (LOAD, ISSUE, 1 busy wait, 5 done waits, WRITEBACK = 9 cycles).
    send_job(BR_type, 4'd5, 5, waits);
    send_job(BR_type, 4'd5, 1, waits);
    chk("b2b_wait_cycles", DATA_W'(waits), DATA_W'(9));
    wait_idle();

    // 6: clear together with a request; the clear wins and CLEAR runs.
    iCtx_clear = 1'b1;
    iReq_valid = 1'b1;
    iReq_type  = BR_type;
    iReq_br_id = 4'd3;
    #1;
    chk("clear_blocks_ready", DATA_W'(oReq_ready), '0);
    @(negedge clk);
    iCtx_clear = 1'b0;
    zero_model();
    send_job(BR_type, 4'd3, 2, waits);
    chk("clear_pulse_wait_cycles", DATA_W'(waits), DATA_W'(16));
    wait_idle();
    send_job(BR_type, 4'd5, 2, waits);
    wait_idle();

    // 5: core never drops done -> ERROR after TIMEOUT cycles in WAIT_BUSY.
    send_job(SYS_type, 4'd1, -1, waits);
    n = 0;
    while (oNext_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("hang_issue_seen", DATA_W'(oNext_valid), DATA_W'(1));
    repeat (TIMEOUT) @(negedge clk);
    chk("error_before_timeout", DATA_W'(oError), '0);
    @(negedge clk);
    chk("error_at_timeout", DATA_W'(oError), DATA_W'(1));
    iReq_valid = 1'b1;
    iReq_type  = SYS_type;
    repeat (5) @(negedge clk);
    #1;
    chk("error_ready_low", DATA_W'(oReq_ready), '0);
    chk("error_sticky", DATA_W'(oError), DATA_W'(1));
    @(negedge clk);
    iReq_valid = 1'b0;

    // Reset leaves ERROR and zeroes every context.
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("error_cleared_by_reset", DATA_W'(oError), '0);
    reset = 1'b0;
    zero_model();
    send_job(BR_type, 4'd5, 1, waits);
    chk("reclear_wait_cycles", DATA_W'(waits), DATA_W'(16));
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
